// File: rtl/pong_match_timer_if.sv
// rtl/pong_match_timer_if.sv - control pulses and display/status outputs of the match timer
interface pong_match_timer_if;
   logic       start;
   logic       pause;
   logic       clear;
   logic [3:0] min;
   logic [3:0] sec1;
   logic [3:0] sec2;
   logic       running;
   logic       expired;
   logic       time_up;
   logic       blank;

   modport master (
      output start, pause, clear,
      input  min, sec1, sec2, running, expired, time_up, blank
   );

   modport slave (
      input  start, pause, clear,
      output min, sec1, sec2, running, expired, time_up, blank
   );
endinterface

// File: rtl/pong_match_timer.sv
// rtl/pong_match_timer.sv - BCD mm:ss match clock with 1 Hz prescaler and run/pause/expire FSM
// Defining PONG_TIMER_BLINK_EN makes blank toggle every CLK_HZ/2 cycles while expired.
module pong_match_timer #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int START_MIN = 3,
   parameter int START_SEC = 0
) (
   input  logic               clk,
   input  logic               rst,
   pong_match_timer_if.slave  tmr
);

   typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;

   localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] TICK_AT = PW'(CLK_HZ - 1);
   localparam logic [3:0] RST_MIN  = 4'(START_MIN);
   localparam logic [3:0] RST_SEC1 = 4'(START_SEC / 10);
   localparam logic [3:0] RST_SEC2 = 4'(START_SEC % 10);
   localparam bit PRESET_ZERO = (START_MIN == 0) && (START_SEC == 0);
`ifdef PONG_TIMER_BLINK_EN
   localparam logic BLINK = 1'b1;
   localparam logic [PW-1:0] HALF_AT = PW'(CLK_HZ / 2 - 1);
`else
   localparam logic BLINK = 1'b0;
`endif

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    min_q, min_d, sec1_q, sec1_d, sec2_q, sec2_d;
   logic          running_q, expired_q, time_up_q, time_up_d, blank_q, blank_d;
   logic [3:0]    dec_min, dec_sec1, dec_sec2;
   logic          dec_zero;

   // One-second BCD borrow chain; saturates at 0:00.
   always_comb begin
      dec_min  = min_q;
      dec_sec1 = sec1_q;
      dec_sec2 = sec2_q;
      if (sec2_q != 4'd0) begin
         dec_sec2 = sec2_q - 4'd1;
      end else if (sec1_q != 4'd0) begin
         dec_sec1 = sec1_q - 4'd1;
         dec_sec2 = 4'd9;
      end else if (min_q != 4'd0) begin
         dec_min  = min_q - 4'd1;
         dec_sec1 = 4'd5;
         dec_sec2 = 4'd9;
      end
      dec_zero = (dec_min == 4'd0) && (dec_sec1 == 4'd0) && (dec_sec2 == 4'd0);
   end

   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      min_d     = min_q;
      sec1_d    = sec1_q;
      sec2_d    = sec2_q;
      time_up_d = 1'b0;
      blank_d   = blank_q;
      if (tmr.clear) begin
         state_d = IDLE;
         presc_d = '0;
         min_d   = RST_MIN;
         sec1_d  = RST_SEC1;
         sec2_d  = RST_SEC2;
         blank_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (tmr.start) begin
                  presc_d = '0;
                  if (PRESET_ZERO) begin
                     state_d   = EXPIRED;
                     time_up_d = 1'b1;
                     blank_d   = BLINK;
                  end else begin
                     state_d = RUNNING;
                  end
               end
            end
            RUNNING: begin
               if (presc_q == TICK_AT) begin
                  presc_d = '0;
                  min_d   = dec_min;
                  sec1_d  = dec_sec1;
                  sec2_d  = dec_sec2;
                  if (dec_zero) begin
                     state_d   = EXPIRED;
                     time_up_d = 1'b1;
                     blank_d   = BLINK;
                  end else if (tmr.pause) begin
                     state_d = PAUSED;
                  end
               end else if (tmr.pause) begin
                  state_d = PAUSED;
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            PAUSED: begin
               if (tmr.start || tmr.pause) state_d = RUNNING;
            end
            EXPIRED: begin
`ifdef PONG_TIMER_BLINK_EN
               if (presc_q == HALF_AT) begin
                  presc_d = '0;
                  blank_d = ~blank_q;
               end else begin
                  presc_d = presc_q + PW'(1);
               end
`endif
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         min_q     <= RST_MIN;
         sec1_q    <= RST_SEC1;
         sec2_q    <= RST_SEC2;
         running_q <= 1'b0;
         expired_q <= 1'b0;
         time_up_q <= 1'b0;
         blank_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         min_q     <= min_d;
         sec1_q    <= sec1_d;
         sec2_q    <= sec2_d;
         running_q <= (state_d == RUNNING);
         expired_q <= (state_d == EXPIRED);
         time_up_q <= time_up_d;
         blank_q   <= blank_d;
      end
   end

   assign tmr.min     = min_q;
   assign tmr.sec1    = sec1_q;
   assign tmr.sec2    = sec2_q;
   assign tmr.running = running_q;
   assign tmr.expired = expired_q;
   assign tmr.time_up = time_up_q;
   assign tmr.blank   = blank_q;

endmodule

// File: tb/tb_pong_match_timer.sv
// tb/tb_pong_match_timer.sv - vector table, expiry sequence and randomized model check of pong_match_timer
module tb_pong_match_timer;
   localparam int HZ = 4;
   localparam int A_PRESET = 65;
`ifdef PONG_TIMER_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pong_match_timer_if a_if ();
   pong_match_timer_if b_if ();

   pong_match_timer #(.CLK_HZ(HZ), .START_MIN(1), .START_SEC(5)) dut_a (
      .clk(clk), .rst(rst), .tmr(a_if.slave)
   );
   pong_match_timer #(.CLK_HZ(HZ), .START_MIN(0), .START_SEC(2)) dut_b (
      .clk(clk), .rst(rst), .tmr(b_if.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      bit s, p, c;
      int idle;
      int mn, s1, s2, run;
   } vec_t;
   vec_t vt[15];

   // Reference model: remaining time in whole seconds plus cycles into the current second.
   int m_mode, m_rem, m_cyc, m_tu, m_blank, m_bcnt;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input bit r, input bit as, input bit ap, input bit ac,
                       input bit bs, input bit bp, input bit bc);
      @(negedge clk);
      rst = r;
      a_if.start = as; a_if.pause = ap; a_if.clear = ac;
      b_if.start = bs; b_if.pause = bp; b_if.clear = bc;
      @(posedge clk);
      #1;
      a_if.start = 1'b0; a_if.pause = 1'b0; a_if.clear = 1'b0;
      b_if.start = 1'b0; b_if.pause = 1'b0; b_if.clear = 1'b0;
   endtask

   task automatic check_a(input string tag, input int mn, input int s1, input int s2,
                          input int run, input int ex, input int tu, input int bl);
      chk({tag, ".min"},     int'(a_if.min),     mn);
      chk({tag, ".sec1"},    int'(a_if.sec1),    s1);
      chk({tag, ".sec2"},    int'(a_if.sec2),    s2);
      chk({tag, ".running"}, int'(a_if.running), run);
      chk({tag, ".expired"}, int'(a_if.expired), ex);
      chk({tag, ".time_up"}, int'(a_if.time_up), tu);
      chk({tag, ".blank"},   int'(a_if.blank),   bl);
   endtask

   task automatic check_b(input string tag, input int mn, input int s1, input int s2,
                          input int run, input int ex, input int tu, input int bl);
      chk({tag, ".min"},     int'(b_if.min),     mn);
      chk({tag, ".sec1"},    int'(b_if.sec1),    s1);
      chk({tag, ".sec2"},    int'(b_if.sec2),    s2);
      chk({tag, ".running"}, int'(b_if.running), run);
      chk({tag, ".expired"}, int'(b_if.expired), ex);
      chk({tag, ".time_up"}, int'(b_if.time_up), tu);
      chk({tag, ".blank"},   int'(b_if.blank),   bl);
   endtask

   task automatic model_step(input bit r, input bit s, input bit p, input bit c);
      m_tu = 0;
      if (r || c) begin
         m_mode = 0; m_rem = A_PRESET; m_cyc = 0; m_blank = 0; m_bcnt = 0;
      end else begin
         case (m_mode)
            0: if (s) begin
                  m_cyc = 0;
                  if (m_rem == 0) begin
                     m_mode = 3; m_tu = 1; m_blank = BLINK; m_bcnt = 0;
                  end else m_mode = 1;
               end
            1: begin
                  if (m_cyc == HZ - 1) begin
                     m_cyc = 0;
                     m_rem = m_rem - 1;
                     if (m_rem == 0) begin
                        m_mode = 3; m_tu = 1; m_blank = BLINK; m_bcnt = 0;
                     end else if (p) m_mode = 2;
                  end else if (p) m_mode = 2;
                  else m_cyc = m_cyc + 1;
               end
            2: if (s || p) m_mode = 1;
            default: if (BLINK) begin
                  m_bcnt = m_bcnt + 1;
                  if (m_bcnt == HZ / 2) begin
                     m_bcnt = 0;
                     m_blank = 1 - m_blank;
                  end
               end
         endcase
      end
   endtask

   initial begin
      int bl_seq[6];
      bl_seq[0] = 1; bl_seq[1] = 1; bl_seq[2] = 0; bl_seq[3] = 0; bl_seq[4] = 1; bl_seq[5] = 1;

      //           s  p  c  idle  mn s1 s2 run
      vt[0]  = '{0, 0, 0, 19,   1, 0, 5, 0};
      vt[1]  = '{1, 0, 0, 0,    1, 0, 5, 1};
      vt[2]  = '{0, 0, 0, 3,    1, 0, 4, 1};
      vt[3]  = '{0, 0, 0, 19,   0, 5, 9, 1};
      vt[4]  = '{0, 0, 0, 1,    0, 5, 9, 1};
      vt[5]  = '{0, 1, 0, 9,    0, 5, 9, 0};
      vt[6]  = '{1, 0, 0, 0,    0, 5, 9, 1};
      vt[7]  = '{0, 0, 0, 0,    0, 5, 9, 1};
      vt[8]  = '{0, 0, 0, 0,    0, 5, 8, 1};
      vt[9]  = '{0, 1, 1, 0,    1, 0, 5, 0};
      vt[10] = '{1, 0, 0, 0,    1, 0, 5, 1};
      vt[11] = '{0, 0, 0, 2,    1, 0, 5, 1};
      vt[12] = '{0, 0, 0, 0,    1, 0, 4, 1};
      vt[13] = '{0, 1, 0, 0,    1, 0, 4, 0};
      vt[14] = '{0, 0, 1, 0,    1, 0, 5, 0};

      a_if.start = 1'b0; a_if.pause = 1'b0; a_if.clear = 1'b0;
      b_if.start = 1'b0; b_if.pause = 1'b0; b_if.clear = 1'b0;
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      check_a("reset_a", 1, 0, 5, 0, 0, 0, 0);
      check_b("reset_b", 0, 0, 2, 0, 0, 0, 0);

      for (int i = 0; i < 15; i++) begin
         step(0, vt[i].s, vt[i].p, vt[i].c, 0, 0, 0);
         for (int k = 0; k < vt[i].idle; k++) step(0, 0, 0, 0, 0, 0, 0);
         check_a($sformatf("vec%0d", i), vt[i].mn, vt[i].s1, vt[i].s2, vt[i].run, 0, 0, 0);
      end

      // Expiry from 0:02: last second, entry edge, then ignored start/pause and blink pattern.
      step(0, 0, 0, 0, 1, 0, 0);
      check_b("b_start", 0, 0, 2, 1, 0, 0, 0);
      for (int k = 0; k < 7; k++) step(0, 0, 0, 0, 0, 0, 0);
      check_b("b_last_sec", 0, 0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      check_b("b_expire", 0, 0, 0, 0, 1, 1, BLINK ? bl_seq[0] : 0);
      for (int k = 1; k < 6; k++) begin
         step(0, 0, 0, 0, k == 2, k == 3, 0);
         check_b($sformatf("b_exp%0d", k), 0, 0, 0, 0, 1, 0, BLINK ? bl_seq[k] : 0);
      end
      step(0, 0, 0, 0, 0, 0, 1);
      check_b("b_clear", 0, 0, 2, 0, 0, 0, 0);

      // Randomized run of instance A against the reference model.
      step(1, 0, 0, 0, 0, 0, 0);
      model_step(1, 0, 0, 0);
      for (int i = 0; i < 6000; i++) begin
         bit r, s, p, c;
         r = ($urandom % 2048) == 0;
         s = ($urandom % 8) == 0;
         p = ($urandom % 16) == 0;
         c = ($urandom % 1024) == 0;
         step(r, s, p, c, 0, 0, 0);
         model_step(r, s, p, c);
         check_a($sformatf("rnd%0d", i), m_rem / 60, (m_rem % 60) / 10, m_rem % 10,
                 m_mode == 1, m_mode == 3, m_tu, m_blank);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
